// File: rtl/csla_sub_pipe.sv
// csla_sub_pipe -- two-stage pipelined carry-select subtractor, D = A - B.
//
// The operation is A + ~B + 1, using the same segmentation as the carry-select
// adder: a low ripple segment of RCA_WIDTH bits, then PRE_UNIT_NUM blocks of
// PRE_WIDTH bits.
//   Stage 1 registers the low segment sum and both conditional sums of every
//           block (carry-in 0 and carry-in 1).
//   Stage 2 walks the carry-select chain and registers the result and flags.
// A valid/ready handshake with combinational back-pressure lets the block
// stream one result per clock when downstream is ready.
//
// Optional feature (macro CSLA_SUB_ABS_EN):
//   defined   -> a second chain computes B - A, and o_D = |A - B|.
//   undefined -> o_D = A - B mod 2^WIDTH; the B - A logic does not exist.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   i_valid  in   operand pair valid
//   o_ready  out  operand pair can be accepted this cycle
//   i_A      in   minuend, unsigned, WIDTH bits
//   i_B      in   subtrahend, unsigned, WIDTH bits
//   o_valid  out  result valid
//   i_ready  in   downstream accepts the result
//   o_D      out  difference (or magnitude under CSLA_SUB_ABS_EN)
//   o_neg    out  A < B (borrow out)
//   o_zero   out  A == B

// One carry-select block: both conditional sums of x + ~y.
module csla_sub_cblk #(
    parameter int W = 6
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W:0]   s0_o,
    output logic [W:0]   s1_o
);
    assign s0_o = {1'b0, x_i} + {1'b0, ~y_i};
    assign s1_o = {1'b0, x_i} + {1'b0, ~y_i} + {{W{1'b0}}, 1'b1};
endmodule

module csla_sub_pipe #(
    parameter int WIDTH        = 29,
    parameter int PRE_WIDTH    = 6,
    parameter int PRE_UNIT_NUM = 4,
    parameter int RCA_WIDTH    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_D,
    output logic             o_neg,
    output logic             o_zero
);

    if (WIDTH != RCA_WIDTH + PRE_WIDTH * PRE_UNIT_NUM) begin : g_bad_cfg
        $error("csla_sub_pipe: WIDTH must equal RCA_WIDTH + PRE_WIDTH*PRE_UNIT_NUM");
    end

    typedef logic [PRE_UNIT_NUM-1:0][PRE_WIDTH:0] blk_t;

    // Walk the select chain: the low carry picks block 0, each block's
    // selected carry-out picks the next. Returns {carry_out, difference}.
    function automatic logic [WIDTH:0] resolve(input logic [RCA_WIDTH:0] lo,
                                               input blk_t s0,
                                               input blk_t s1);
        logic                 carry;
        logic [PRE_WIDTH:0]   sel;
        logic [WIDTH-1:0]     raw;
        carry = lo[RCA_WIDTH];
        raw   = '0;
        raw[RCA_WIDTH-1:0] = lo[RCA_WIDTH-1:0];
        for (int i = 0; i < PRE_UNIT_NUM; i++) begin
            sel   = carry ? s1[i] : s0[i];
            raw[RCA_WIDTH + i*PRE_WIDTH +: PRE_WIDTH] = sel[PRE_WIDTH-1:0];
            carry = sel[PRE_WIDTH];
        end
        return {carry, raw};
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid_q, o_valid_q;
    logic en1, en2;

    assign en2     = !o_valid_q || i_ready;
    assign en1     = !s1_valid_q || en2;
    assign o_ready = en1;

    // ---------------- stage 1: A - B conditional sums ----------------
    logic [RCA_WIDTH:0] lo_ab_d, lo_ab_q;
    blk_t               s0_ab_d, s1_ab_d, s0_ab_q, s1_ab_q;

    assign lo_ab_d = {1'b0, i_A[RCA_WIDTH-1:0]} + {1'b0, ~i_B[RCA_WIDTH-1:0]}
                   + {{RCA_WIDTH{1'b0}}, 1'b1};

    for (genvar i = 0; i < PRE_UNIT_NUM; i++) begin : g_ab
        csla_sub_cblk #(.W(PRE_WIDTH)) u_blk (
            .x_i  (i_A[RCA_WIDTH + i*PRE_WIDTH +: PRE_WIDTH]),
            .y_i  (i_B[RCA_WIDTH + i*PRE_WIDTH +: PRE_WIDTH]),
            .s0_o (s0_ab_d[i]),
            .s1_o (s1_ab_d[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            lo_ab_q    <= '0;
            s0_ab_q    <= '0;
            s1_ab_q    <= '0;
        end else if (en1) begin
            s1_valid_q <= i_valid && en1;
            lo_ab_q    <= lo_ab_d;
            s0_ab_q    <= s0_ab_d;
            s1_ab_q    <= s1_ab_d;
        end
    end

    // ---------------- stage 2: resolve ----------------
    logic [WIDTH:0]   res_ab;
    logic [WIDTH-1:0] d_d;
    logic             neg_d, zero_d;

    assign res_ab = resolve(lo_ab_q, s0_ab_q, s1_ab_q);
    assign neg_d  = !res_ab[WIDTH];
    assign zero_d = (res_ab[WIDTH-1:0] == '0);

`ifdef CSLA_SUB_ABS_EN
    // Second chain for B - A so the magnitude is ready without a negate stage.
    logic [RCA_WIDTH:0] lo_ba_d, lo_ba_q;
    blk_t               s0_ba_d, s1_ba_d, s0_ba_q, s1_ba_q;
    logic [WIDTH:0]     res_ba;

    assign lo_ba_d = {1'b0, i_B[RCA_WIDTH-1:0]} + {1'b0, ~i_A[RCA_WIDTH-1:0]}
                   + {{RCA_WIDTH{1'b0}}, 1'b1};

    for (genvar i = 0; i < PRE_UNIT_NUM; i++) begin : g_ba
        csla_sub_cblk #(.W(PRE_WIDTH)) u_blk (
            .x_i  (i_B[RCA_WIDTH + i*PRE_WIDTH +: PRE_WIDTH]),
            .y_i  (i_A[RCA_WIDTH + i*PRE_WIDTH +: PRE_WIDTH]),
            .s0_o (s0_ba_d[i]),
            .s1_o (s1_ba_d[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_ba_q <= '0;
            s0_ba_q <= '0;
            s1_ba_q <= '0;
        end else if (en1) begin
            lo_ba_q <= lo_ba_d;
            s0_ba_q <= s0_ba_d;
            s1_ba_q <= s1_ba_d;
        end
    end

    assign res_ba = resolve(lo_ba_q, s0_ba_q, s1_ba_q);
    assign d_d    = neg_d ? res_ba[WIDTH-1:0] : res_ab[WIDTH-1:0];
`else
    assign d_d    = res_ab[WIDTH-1:0];
`endif

    logic [WIDTH-1:0] o_D_q;
    logic             o_neg_q, o_zero_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_q <= 1'b0;
            o_D_q     <= '0;
            o_neg_q   <= 1'b0;
            o_zero_q  <= 1'b0;
        end else if (en2) begin
            o_valid_q <= s1_valid_q;
            o_D_q     <= d_d;
            o_neg_q   <= neg_d;
            o_zero_q  <= zero_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_D     = o_D_q;
    assign o_neg   = o_neg_q;
    assign o_zero  = o_zero_q;

endmodule

// File: tb/tb_csla_sub_pipe.sv
module tb_csla_sub_pipe;
    localparam int          W   = 29;
    localparam logic [31:0] MAX = 32'h1FFF_FFFF;
`ifdef CSLA_SUB_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, o_ready, o_valid, i_ready, o_neg, o_zero;
    logic [W-1:0] i_A, i_B, o_D;

    always #5 clk = ~clk;

    csla_sub_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_A     (i_A),
        .i_B     (i_B),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_D     (o_D),
        .o_neg   (o_neg),
        .o_zero  (o_zero)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    typedef struct {
        logic [31:0] d;
        logic        neg;
        logic        zero;
    } exp_t;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.neg  = (a < b);
        e.zero = (a == b);
        if (ABS && a < b) e.d = (b - a) & MAX;
        else              e.d = (a - b) & MAX;
        return e;
    endfunction

    // Scoreboard-driven cycle: drive on negedge, check 1 time unit later.
    exp_t        q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] held_d;
    logic        held_n, held_z;
    int          popped = 0;

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic r, output logic acc);
        exp_t e;
        @(negedge clk);
        i_valid = v; i_A = a[W-1:0]; i_B = b[W-1:0]; i_ready = r;
        #1;
        if (hold_prev) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_d",     32'(o_D),     held_d);
            chk("hold_neg",   32'(o_neg),   32'(held_n));
            chk("hold_zero",  32'(o_zero),  32'(held_z));
        end
        // Two items in flight means both stages are occupied.
        chk("o_ready", 32'(o_ready), 32'(!(q.size() == 2 && !r)));
        if (o_valid && r) begin
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL spurious_out: got result 0x%0h, expected none", o_D);
            end else begin
                e = q.pop_front();
                chk("sb_d",    32'(o_D),    e.d);
                chk("sb_neg",  32'(o_neg),  32'(e.neg));
                chk("sb_zero", 32'(o_zero), 32'(e.zero));
                popped++;
            end
        end
        acc = v && o_ready;
        if (acc) q.push_back(model(a, b));
        hold_prev = o_valid && !r;
        held_d = 32'(o_D); held_n = o_neg; held_z = o_zero;
    endtask

    typedef struct {
        logic [31:0] a, b, d;
        logic        neg, zero;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   sent, p0, accn;
        logic [31:0] a, b;

        tbl[0] = '{32'd100, 32'd37,  32'd63, 1'b0, 1'b0};
        tbl[1] = '{32'd37,  32'd100, ABS ? 32'd63 : 32'h1FFF_FFC1, 1'b1, 1'b0};
        tbl[2] = '{MAX,     MAX,     32'd0,  1'b0, 1'b1};
        tbl[3] = '{32'h20,  32'h1,   32'h1F, 1'b0, 1'b0};
        tbl[4] = '{32'd0,   32'd0,   32'd0,  1'b0, 1'b1};
        tbl[5] = '{32'd0,   MAX,     ABS ? MAX : 32'd1, 1'b1, 1'b0};
        tbl[6] = '{MAX,     32'd0,   MAX,    1'b0, 1'b0};
        tbl[7] = '{32'h800, 32'h1,   32'h7FF, 1'b0, 1'b0};

        // Reset
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_A = '0; i_B = '0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_d",     32'(o_D),     32'd0);
        chk("rst_neg",   32'(o_neg),   32'd0);
        chk("rst_zero",  32'(o_zero),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(o_ready), 32'd1);

        // Table vectors with exact latency
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_A = tbl[i].a[W-1:0]; i_B = tbl[i].b[W-1:0]; i_ready = 1'b1;
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            chk("tbl_lat1_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
            #1;
            chk("tbl_valid", 32'(o_valid), 32'd1);
            chk("tbl_d",     32'(o_D),     tbl[i].d);
            chk("tbl_neg",   32'(o_neg),   32'(tbl[i].neg));
            chk("tbl_zero",  32'(o_zero),  32'(tbl[i].zero));
        end

        // Back-to-back stream with a downstream stall on cycles 3-5
        hold_prev = 1'b0; sent = 0; p0 = popped;
        for (int c = 0; c < 20; c++) begin
            step(sent < 8, 32'(sent + 50), 32'(sent), !(c >= 3 && c <= 5), acc);
            if (acc) sent++;
        end
        chk("stall_sent",   32'(sent),          32'd8);
        chk("stall_popped", 32'(popped - p0),   32'd8);
        chk("stall_empty",  32'(q.size()),      32'd0);

        // Asynchronous reset with two pairs in flight
        step(1'b1, 32'd7, 32'd3, 1'b1, acc);
        step(1'b1, 32'd9, 32'd4, 1'b1, acc);
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_d",     32'(o_D),     32'd0);
        chk("arst_neg",   32'(o_neg),   32'd0);
        chk("arst_zero",  32'(o_zero),  32'd0);
        q.delete(); hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_rel_ready", 32'(o_ready), 32'd1);
        chk("arst_rel_valid", 32'(o_valid), 32'd0);
        i_valid = 1'b1; i_A = 29'd5; i_B = 29'd5; i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("arst_no_stale", 32'(o_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("arst_55_valid", 32'(o_valid), 32'd1);
        chk("arst_55_zero",  32'(o_zero),  32'd1);
        chk("arst_55_neg",   32'(o_neg),   32'd0);
        chk("arst_55_d",     32'(o_D),     32'd0);

        // Random traffic against the reference model
        accn = 0;
        for (int cyc = 0; cyc < 40000 && accn < 10000; cyc++) begin
            a = $urandom & MAX;
            b = $urandom & MAX;
            case ($urandom_range(0, 15))
                0: b = a;
                1: a = 32'd0;
                2: b = MAX;
                3: a = MAX;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0, acc);
            if (acc) accn++;
        end
        if (accn < 10000) begin
            nvec++; nerr++;
            $display("FAIL rand_accept: got %0d pairs, expected 10000", accn);
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
